change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter COIN_CYCLES, default 4: the number of cycles hopper_pulse is held high for each coin.
REQ-002 SHALL have parameter GAP_CYCLES, default 2: the number of idle cycles between consecutive coins.
REQ-003 SHALL have parameter TIMEOUT, default 8: the maximum number of SENSE cycles to wait for coin_sensed.
REQ-004 SHALL have parameter STOCK_INIT, default 15: the stock value loaded at reset and on refill (4-bit).
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port change, input, 2 bits: the change owed, in coin units 0..3, driven by the vending machine.
REQ-008 SHALL have port change_valid, input, 1 bit: qualifies change.
REQ-009 SHALL have port change_ready, output, 1 bit: high when a request can be accepted.
REQ-010 SHALL have port hopper_pulse, output, 1 bit: the coin-eject drive to the hopper.
REQ-011 SHALL have port coin_sensed, input, 1 bit: the exit sensor, synchronous to clk.
REQ-012 SHALL have port refill, input, 1 bit: reloads stock to STOCK_INIT.
REQ-013 SHALL have port stock, output, 4 bits: the coins remaining in the hopper.
REQ-014 SHALL have port owed, output, 2 bits: the coins still to dispense for the current request.
REQ-015 SHALL have port done, output, 1 bit: a 1-cycle pulse when a request completes.
REQ-016 SHALL have port err_jam, output, 1 bit: sticky flag for a coin_sensed timeout.
REQ-017 SHALL have port err_empty, output, 1 bit: sticky flag for a coin needed while stock is 0.

Function
REQ-018 SHALL implement FSM states IDLE, PULSE, SENSE, GAP, DONE, FAULT.
REQ-019 SHALL assert change_ready only in IDLE; a request is accepted on a clk edge with change_valid && change_ready.
REQ-020 IDLE on accept SHALL load owed = change; go to DONE if change==0, else to PULSE (or to FAULT with err_empty if stock==0).
REQ-021 PULSE SHALL hold hopper_pulse high for exactly COIN_CYCLES cycles, then go to SENSE.
REQ-022 SENSE SHALL wait up to TIMEOUT cycles for coin_sensed.
REQ-023 On coin_sensed in SENSE, SHALL decrement owed and stock by 1 on the same edge; go to DONE if the new owed==0, else to GAP.
REQ-024 If TIMEOUT SENSE cycles elapse without coin_sensed, SHALL set err_jam and go to FAULT, with owed and stock unchanged.
REQ-025 GAP SHALL last GAP_CYCLES cycles, then go to PULSE if stock>0, else set err_empty and go to FAULT.
REQ-026 DONE SHALL assert done for one cycle, then go to IDLE; owed reads 0 in DONE.
REQ-027 coin_sensed outside SENSE SHALL be ignored: no counter change, no error.
REQ-028 FAULT SHALL hold hopper_pulse low and change_ready low, and hold owed.
REQ-029 refill in FAULT SHALL clear err_jam and err_empty, load stock=STOCK_INIT, and go to GAP to resume owed.
REQ-030 refill in any other state SHALL load stock=STOCK_INIT without changing state.
REQ-031 refill SHALL win over a same-edge decrement (stock=STOCK_INIT).
REQ-032 stock SHALL saturate at 0 and never wrap.
REQ-033 owed SHALL never underflow.
REQ-034 change_valid while not ready SHALL be ignored; there is no queuing.
REQ-035 Worst-case request latency without faults SHALL be change*(COIN_CYCLES+1+sense_delay)+(change-1)*GAP_CYCLES+2 cycles.

Reset
REQ-036 rst low SHALL asynchronously force state IDLE, stock=STOCK_INIT, owed=0, hopper_pulse=0, done=0, err_jam=0, err_empty=0, change_ready=0.
REQ-037 change_ready SHALL rise on the first clk edge after rst deasserts.
REQ-038 Reset mid-dispense SHALL abort immediately: hopper_pulse drops with no clock required, and the owed count is lost.

Structure
REQ-039 A shared package SHALL hold the FSM state encoding, the coin-unit width (2) and the stock width (4).
REQ-040 The block SHALL contain one sub-module, dispense_timer: a loadable down-counter shared by PULSE, SENSE and GAP, with expiry flag.
REQ-041 No other hierarchy SHALL be used.

Verification
REQ-042 Reset then change=2 with valid, coin_sensed 1 cycle after each SENSE entry -> two 4-cycle pulses separated by SENSE+GAP, stock 15->13, one done pulse, owed 2->1->0.
REQ-043 change=0 request -> done 2 cycles after accept, no hopper_pulse, stock stays 15.
REQ-044 change=1 with coin_sensed withheld -> err_jam set after 8 SENSE cycles, owed=1; refill -> errors clear, coin re-dispensed, done.
REQ-045 stock reduced to 1 and change=3 -> one coin dispensed, err_empty set, owed=2, FAULT; refill -> stock=15, two more coins, final stock 13.
REQ-046 rst asserted during the 2nd PULSE cycle -> hopper_pulse low asynchronously, stock=15, owed=0, ready high 1 cycle after release.
REQ-047 refill asserted on the same edge as a coin_sensed decrement -> stock=15, not 14; change_valid pulsed while busy -> ignored.

Source files
------------

// File: rtl/change_dispenser_pkg.sv
// change_dispenser_pkg: shared FSM encoding and datapath widths for the change dispenser
package change_dispenser_pkg;
   localparam int COIN_W  = 2;
   localparam int STOCK_W = 4;
   localparam int TIMER_W = 8;
   typedef enum logic [2:0] {IDLE, PULSE, SENSE, GAP, DONE, FAULT} state_t;
endpackage

// File: rtl/change_dispenser_timer.sv
// dispense_timer: loadable down-counter shared by the PULSE, SENSE and GAP phases
module dispense_timer
   import change_dispenser_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [TIMER_W-1:0] value,
   output logic               expired
);
   logic [TIMER_W-1:0] cnt;
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt <= '0;
      else if (load) cnt <= value;
      else if (cnt != '0) cnt <= cnt - TIMER_W'(1);
   assign expired = cnt == '0;
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pulses a coin hopper once per owed coin, confirms each coin on the exit
// sensor, and tracks stock with sticky jam/empty faults that a refill clears
module change_dispenser
   import change_dispenser_pkg::*;
#(
   parameter int                 COIN_CYCLES = 4,
   parameter int                 GAP_CYCLES  = 2,
   parameter int                 TIMEOUT     = 8,
   parameter logic [STOCK_W-1:0] STOCK_INIT  = 4'd15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [COIN_W-1:0]  change,
   input  logic               change_valid,
   output logic               change_ready,
   output logic               hopper_pulse,
   input  logic               coin_sensed,
   input  logic               refill,
   output logic [STOCK_W-1:0] stock,
   output logic [COIN_W-1:0]  owed,
   output logic               done,
   output logic               err_jam,
   output logic               err_empty
);
   localparam logic [TIMER_W-1:0] PULSE_LD = TIMER_W'(COIN_CYCLES - 1);
   localparam logic [TIMER_W-1:0] SENSE_LD = TIMER_W'(TIMEOUT - 1);
   localparam logic [TIMER_W-1:0] GAP_LD   = TIMER_W'(GAP_CYCLES - 1);
   state_t state, nxt;
   logic armed, expired, accept, sense_hit, stock_ok, set_jam, set_empty;
   logic [TIMER_W-1:0] ld_val;
   assign change_ready = armed && state == IDLE;
   assign hopper_pulse = state == PULSE;
   assign done         = state == DONE;
   assign accept       = change_valid && change_ready;
   assign sense_hit    = state == SENSE && coin_sensed;
   // a refill landing on the decision edge counts as stock being available
   assign stock_ok     = stock != '0 || refill;
   assign ld_val       = nxt == PULSE ? PULSE_LD : nxt == SENSE ? SENSE_LD : GAP_LD;
   always_comb begin
      nxt       = state;
      set_jam   = 1'b0;
      set_empty = 1'b0;
      unique case (state)
         IDLE: if (accept) begin
            nxt       = change == '0 ? DONE : stock_ok ? PULSE : FAULT;
            set_empty = change != '0 && !stock_ok;
         end
         PULSE: nxt = expired ? SENSE : PULSE;
         SENSE: if (coin_sensed) nxt = owed <= COIN_W'(1) ? DONE : GAP;
            else if (expired) begin
               nxt     = FAULT;
               set_jam = 1'b1;
            end
         GAP: if (expired) begin
            nxt       = stock_ok ? PULSE : FAULT;
            set_empty = !stock_ok;
         end
         DONE:    nxt = IDLE;
         FAULT:   nxt = refill ? GAP : FAULT;
         default: nxt = IDLE;
      endcase
   end
   dispense_timer u_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (nxt != state),
      .value  (ld_val),
      .expired(expired)
   );
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state     <= IDLE;
         armed     <= 1'b0;
         stock     <= STOCK_INIT;
         owed      <= '0;
         err_jam   <= 1'b0;
         err_empty <= 1'b0;
      end else begin
         state     <= nxt;
         armed     <= 1'b1;
         owed      <= accept ? change : (sense_hit && owed != '0) ? owed - COIN_W'(1) : owed;
         stock     <= refill ? STOCK_INIT : (sense_hit && stock != '0) ? stock - STOCK_W'(1) : stock;
         err_jam   <= (state == FAULT && refill) ? 1'b0 : err_jam | set_jam;
         err_empty <= (state == FAULT && refill) ? 1'b0 : err_empty | set_empty;
      end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed requests with a scoreboard of expected done/jam/empty events
module tb_change_dispenser;
   import change_dispenser_pkg::*;
   typedef struct {int kind; int stk; int ow; int coins; int lat;} ev_t;
   logic clk = 0, rst = 0, change_valid = 0, coin_sensed = 0, refill_s = 0, refill_r = 0;
   logic [1:0] change = 0;
   logic change_ready, hopper_pulse, done, err_jam, err_empty;
   logic [3:0] stock;
   logic [1:0] owed;
   ev_t sb[$];
   int passed = 0, total = 0, cyc = 0, acc = 0, arm = 0, coins = 0, k = 0;
   logic rp = 0, sense_en = 1, ros = 0, pj = 0, pe = 0, php = 0;
   ev_t e;

   change_dispenser dut (
      .clk(clk), .rst(rst), .change(change), .change_valid(change_valid),
      .change_ready(change_ready), .hopper_pulse(hopper_pulse), .coin_sensed(coin_sensed),
      .refill(refill_s | refill_r), .stock(stock), .owed(owed), .done(done),
      .err_jam(err_jam), .err_empty(err_empty)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string name, int act, int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick(int n = 1);
      repeat (n) @(negedge clk);
   endtask

   // which: 0 = change_ready, 1 = err_jam, 2 = err_empty
   task automatic wait_for(int which, string name);
      int t = 0;
      logic s;
      s = which == 0 ? change_ready : which == 1 ? err_jam : err_empty;
      while (!s && t < 300) begin
         tick();
         t++;
         s = which == 0 ? change_ready : which == 1 ? err_jam : err_empty;
      end
      chk(name, int'(s), 1);
   endtask

   task automatic req(logic [1:0] c);
      wait_for(0, "ready_before_req");
      change = c;
      change_valid = 1;
      acc = cyc + 1;
      tick();
      change_valid = 0;
   endtask

   task automatic do_refill();
      refill_s = 1;
      sense_en = 1;
      tick();
      refill_s = 0;
   endtask

   // coin sensor model: coin_sensed one cycle after each SENSE entry
   initial forever begin
      @(negedge clk);
      if (arm == 2) begin
         coin_sensed = 0;
         refill_r = 0;
         arm = 0;
      end else if (arm == 1) begin
         coin_sensed = 1;
         refill_r = ros;
         arm = 2;
      end else if (sense_en && rp && !hopper_pulse) arm = 1;
      rp = hopper_pulse;
   end

   // monitor: pops an expectation whenever done pulses or an error flag rises
   initial forever begin
      @(negedge clk);
      if (!rst) coins = 0;
      else if (hopper_pulse && !php) coins++;
      if (done || (err_jam && !pj) || (err_empty && !pe)) begin
         k = done ? 0 : (err_jam && !pj) ? 1 : 2;
         if (sb.size() == 0) begin
            total++;
            $display("FAIL unexpected_event: got kind %0d expected none", k);
         end else begin
            e = sb.pop_front();
            chk("ev_kind", k, e.kind);
            chk("ev_stock", int'(stock), e.stk);
            chk("ev_owed", int'(owed), e.ow);
            chk("ev_coins", coins, e.coins);
            if (e.lat >= 0) chk("ev_latency", cyc - acc + 2, e.lat);
         end
         coins = 0;
      end
      pj = err_jam;
      pe = err_empty;
      php = hopper_pulse;
   end

   initial begin
      tick(2);
      chk("rst_ready", int'(change_ready), 0);
      chk("rst_stock", int'(stock), 15);
      chk("rst_owed", int'(owed), 0);
      chk("rst_pulse", int'(hopper_pulse), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_jam", int'(err_jam), 0);
      chk("rst_empty", int'(err_empty), 0);
      rst = 1;
      #1 chk("ready_before_edge", int'(change_ready), 0);
      tick();
      chk("ready_after_edge", int'(change_ready), 1);
      // two coins with prompt sensing
      sb.push_back('{0, 13, 0, 2, 16});
      req(2);
      chk("owed_loaded", int'(owed), 2);
      wait_for(0, "idle_c2");
      // zero change
      sb.push_back('{0, 13, 0, 0, 2});
      req(0);
      wait_for(0, "idle_c0");
      // jam then refill resume
      sense_en = 0;
      sb.push_back('{1, 13, 1, 1, 14});
      sb.push_back('{0, 14, 0, 1, -1});
      req(1);
      wait_for(1, "jam_set");
      chk("jam_owed", int'(owed), 1);
      chk("jam_ready", int'(change_ready), 0);
      do_refill();
      chk("jam_cleared", int'(err_jam), 0);
      chk("jam_refill_stock", int'(stock), 15);
      wait_for(0, "idle_jam");
      // drain stock to 1
      for (int i = 0; i < 4; i++) begin
         sb.push_back('{0, 11 - 3 * i, 0, 3, 24});
         req(3);
         wait_for(0, "idle_drain");
      end
      sb.push_back('{0, 1, 0, 1, 8});
      req(1);
      wait_for(0, "idle_drain1");
      // empty hopper mid-request
      sb.push_back('{2, 0, 2, 1, 10});
      sb.push_back('{0, 13, 0, 2, -1});
      req(3);
      wait_for(2, "empty_set");
      chk("empty_owed", int'(owed), 2);
      chk("empty_pulse", int'(hopper_pulse), 0);
      do_refill();
      chk("empty_cleared", int'(err_empty), 0);
      chk("empty_refill_stock", int'(stock), 15);
      wait_for(0, "idle_empty");
      // reset during the second pulse cycle
      req(1);
      chk("pulse_running", int'(hopper_pulse), 1);
      tick();
      rst = 0;
      #1;
      chk("abort_pulse", int'(hopper_pulse), 0);
      chk("abort_stock", int'(stock), 15);
      chk("abort_owed", int'(owed), 0);
      chk("abort_ready", int'(change_ready), 0);
      tick();
      rst = 1;
      #1 chk("rel_ready0", int'(change_ready), 0);
      tick();
      chk("rel_ready1", int'(change_ready), 1);
      // refill on the decrement edge, and valid while busy
      ros = 1;
      sb.push_back('{0, 15, 0, 1, 8});
      req(1);
      tick(2);
      change = 3;
      change_valid = 1;
      tick(3);
      change_valid = 0;
      wait_for(0, "idle_refill_race");
      ros = 0;
      k = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (hopper_pulse) k++;
      end
      chk("no_queued_pulses", k, 0);
      chk("final_owed", int'(owed), 0);
      chk("final_stock", int'(stock), 15);
      chk("scoreboard_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
